// File: rtl/scan_pkg.sv
`default_nettype none
// ============================================================================
// Module      : scan_pkg
// Description : Shared definitions for the truth-table scanner: FSM state
//               encodings, default sizes and input/output bit positions of
//               the function-under-test.
// Revision    : 1.0 - initial release
// ============================================================================
package scan_pkg;

    // Default sizing of the function-under-test
    localparam int NUM_VARS_DEF  = 4;
    localparam int NUM_FUNCS_DEF = 5;
    localparam int SEL_W_DEF     = 3;

    // Scanner FSM state encodings
    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_SWEEP = 2'd1;
    localparam logic [1:0] c_ST_EMIT  = 2'd2;
    localparam logic [1:0] c_ST_FIN   = 2'd3;

    // Bit positions of the function inputs within stim
    localparam int c_BIT_X = 3;
    localparam int c_BIT_Y = 2;
    localparam int c_BIT_W = 1;
    localparam int c_BIT_Z = 0;

    // Bit positions of the function outputs within func_in
    localparam int c_BIT_A = 0;
    localparam int c_BIT_B = 1;
    localparam int c_BIT_C = 2;
    localparam int c_BIT_D = 3;
    localparam int c_BIT_E = 4;

endpackage
`default_nettype wire

// File: rtl/minterm_emitter.sv
`default_nettype none
// ============================================================================
// Module      : minterm_emitter
// Description : Walks a captured truth-table column in ascending order and
//               streams the indices of its set entries over valid/ready.
//               Unset entries are skipped one per cycle; the walk ends after
//               the last set entry is accepted or when nothing set remains.
// Revision    : 1.0 - initial release
// ============================================================================
module minterm_emitter #(
    parameter int NUM_VARS = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load,
    input  logic                     enable,
    input  logic [2**NUM_VARS-1:0]   col,
    input  logic                     m_ready,
    output logic                     m_valid,
    output logic [NUM_VARS-1:0]      m_index,
    output logic                     m_last,
    output logic                     finish
);

    localparam int c_DEPTH = 2**NUM_VARS;

    logic [NUM_VARS-1:0] r_ptr;
    logic                w_hit;
    logic                w_above;

    // Any set entry strictly above the read pointer
    always_comb begin
        w_above = 1'b0;
        for (int k = 0; k < c_DEPTH; k++) begin
            if (k > int'(r_ptr) && col[k]) begin
                w_above = 1'b1;
            end
        end
    end

    assign w_hit   = col[r_ptr];
    assign m_valid = enable & w_hit;
    assign m_index = r_ptr;
    assign m_last  = m_valid & ~w_above;
    // Done once the final beat is taken, or immediately when nothing is left
    assign finish  = enable & ~w_above & (~w_hit | m_ready);

    // Read pointer: restart on load, advance on skip or accepted beat
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (load) begin
            r_ptr <= '0;
        end else if (enable && (!w_hit || m_ready)) begin
            r_ptr <= r_ptr + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/truth_table_scanner.sv
`default_nettype none
// ============================================================================
// Module      : truth_table_scanner
// Description : Sweeps every input combination into an external function-
//               under-test, captures its truth table, then streams the
//               minterm indices of one selected output.
//               Optional macro SCAN_CONST_FLAG_EN adds const_zero/const_one.
// Revision    : 1.0 - initial release
// ============================================================================
module truth_table_scanner
    import scan_pkg::*;
#(
    parameter int NUM_VARS  = NUM_VARS_DEF,
    parameter int NUM_FUNCS = NUM_FUNCS_DEF,
    parameter int SEL_W     = SEL_W_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [SEL_W-1:0]     sel,
    output logic [NUM_VARS-1:0]  stim,
    input  logic [NUM_FUNCS-1:0] func_in,
    output logic                 busy,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [NUM_VARS-1:0]  m_index,
    output logic                 m_last,
    output logic [NUM_VARS:0]    count,
    output logic                 done
`ifdef SCAN_CONST_FLAG_EN
    ,
    output logic                 const_zero,
    output logic                 const_one
`endif
);

    localparam int c_DEPTH = 2**NUM_VARS;
    localparam logic [NUM_VARS:0] c_FULL = {1'b1, {NUM_VARS{1'b0}}};

    logic [1:0]           r_state;
    logic [1:0]           w_next_state;
    logic [SEL_W-1:0]     r_sel;
    logic                 r_sel_ok;
    logic [NUM_VARS-1:0]  r_stim;
    logic [NUM_VARS:0]    r_count;
    logic [NUM_FUNCS-1:0] r_table [c_DEPTH];
    logic [c_DEPTH-1:0]   w_col;
    logic                 w_live_bit;
    logic                 w_sweep_last;
    logic                 w_emit_load;
    logic                 w_emit_en;
    logic                 w_emit_finish;

    assign w_sweep_last = (r_stim == {NUM_VARS{1'b1}});
    assign w_emit_load  = (r_state == c_ST_SWEEP) && w_sweep_last;
    assign w_emit_en    = (r_state == c_ST_EMIT);

    assign stim  = r_stim;
    assign count = r_count;
    assign busy  = (r_state != c_ST_IDLE);
    assign done  = (r_state == c_ST_FIN);

    // Selected output of the live response; out-of-range selects read as 0
    always_comb begin
        w_live_bit = 1'b0;
        for (int i = 0; i < NUM_FUNCS; i++) begin
            if (r_sel_ok && r_sel == SEL_W'(i)) begin
                w_live_bit = func_in[i];
            end
        end
    end

    // Selected column of the captured table, one bit per minterm
    always_comb begin
        for (int j = 0; j < c_DEPTH; j++) begin
            w_col[j] = 1'b0;
            for (int i = 0; i < NUM_FUNCS; i++) begin
                if (r_sel_ok && r_sel == SEL_W'(i)) begin
                    w_col[j] = r_table[j][i];
                end
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE:  if (start)         w_next_state = c_ST_SWEEP;
            c_ST_SWEEP: if (w_sweep_last)  w_next_state = c_ST_EMIT;
            c_ST_EMIT:  if (w_emit_finish) w_next_state = c_ST_FIN;
            default:                       w_next_state = c_ST_IDLE;
        endcase
    end

    // Select latch, stimulus counter, table capture and minterm count
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sel    <= '0;
            r_sel_ok <= 1'b0;
            r_stim   <= '0;
            r_count  <= '0;
            for (int j = 0; j < c_DEPTH; j++) begin
                r_table[j] <= '0;
            end
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_sel    <= sel;
                        r_sel_ok <= (int'(sel) < NUM_FUNCS);
                        r_stim   <= '0;
                        r_count  <= '0;
                        for (int j = 0; j < c_DEPTH; j++) begin
                            r_table[j] <= '0;
                        end
                    end
                end
                c_ST_SWEEP: begin
                    r_table[r_stim] <= func_in;
                    r_stim          <= r_stim + 1'b1;
                    if (w_live_bit) begin
                        r_count <= r_count + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef SCAN_CONST_FLAG_EN
    logic r_const_zero;
    logic r_const_one;

    assign const_zero = r_const_zero;
    assign const_one  = r_const_one;

    // Constant-function flags, resolved as the scan finishes
    always_ff @(posedge clk) begin
        if (reset) begin
            r_const_zero <= 1'b0;
            r_const_one  <= 1'b0;
        end else if (r_state == c_ST_IDLE && start) begin
            r_const_zero <= 1'b0;
            r_const_one  <= 1'b0;
        end else if (w_emit_en && w_emit_finish) begin
            r_const_zero <= (r_count == '0);
            r_const_one  <= (r_count == c_FULL);
        end
    end
`endif

    minterm_emitter #(
        .NUM_VARS (NUM_VARS)
    ) u_emitter (
        .clk     (clk),
        .rst     (reset),
        .load    (w_emit_load),
        .enable  (w_emit_en),
        .col     (w_col),
        .m_ready (m_ready),
        .m_valid (m_valid),
        .m_index (m_index),
        .m_last  (m_last),
        .finish  (w_emit_finish)
    );

endmodule
`default_nettype wire

// File: tb/tb_truth_table_scanner.sv
`default_nettype none
// ============================================================================
// Module      : tb_truth_table_scanner
// Description : Self-checking bench for truth_table_scanner. A truth-table
//               model of the function-under-test feeds func_in; expected
//               minterm beats are queued per scan and checked by a monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_truth_table_scanner;
    import scan_pkg::*;

    localparam int NV = 4;
    localparam int NF = 5;
    localparam int SW = 3;
    localparam int DEPTH = 16;

    typedef struct packed {
        logic [3:0] idx;
        logic       last;
    } beat_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [SW-1:0] sel;
    logic [NV-1:0] stim;
    logic [NF-1:0] func_in;
    logic          busy;
    logic          m_valid;
    logic          m_ready;
    logic [NV-1:0] m_index;
    logic          m_last;
    logic [NV:0]   count;
    logic          done;
`ifdef SCAN_CONST_FLAG_EN
    logic          const_zero;
    logic          const_one;
`endif

    logic [NF-1:0] tt [DEPTH];
    beat_t         exp_q [$];
    beat_t         mon_b;
    int            total = 0;
    int            bad = 0;
    int            exp_count = 0;
    bit            scan_open = 0;
    int            rdy_mode = 0;
    int            stall_left = 0;
    int            stall6 = 0;
    int            done_seen = 0;
    logic          prev_stall = 1'b0;
    logic [3:0]    prev_idx = '0;
    logic          prev_last = 1'b0;
    logic          prev_done = 1'b0;

    assign func_in = tt[stim];

    always #5 clk = ~clk;

    truth_table_scanner #(.NUM_VARS(NV), .NUM_FUNCS(NF), .SEL_W(SW)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .sel     (sel),
        .stim    (stim),
        .func_in (func_in),
        .busy    (busy),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_index (m_index),
        .m_last  (m_last),
        .count   (count),
        .done    (done)
`ifdef SCAN_CONST_FLAG_EN
        ,
        .const_zero (const_zero),
        .const_one  (const_one)
`endif
    );

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: minterms of output s are the rows where that output is 1
    task automatic model_push(input int s);
        int    n;
        int    lastidx;
        beat_t b;
        n = 0;
        lastidx = -1;
        exp_q.delete();
        for (int i = 0; i < DEPTH; i++) begin
            if (s < NF && tt[i][s]) begin
                n++;
                lastidx = i;
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (s < NF && tt[i][s]) begin
                b.idx  = 4'(i);
                b.last = (i == lastidx);
                exp_q.push_back(b);
            end
        end
        exp_count = n;
    endtask

    task automatic fill_const(input logic [NF-1:0] v);
        for (int i = 0; i < DEPTH; i++) tt[i] = v;
    endtask

    // Guide functions: b = 1, c = xz+wz+yz, d = xz+yz+wz'; a and e random
    task automatic fill_guide();
        logic x, y, w, z;
        for (int i = 0; i < DEPTH; i++) begin
            x = i[c_BIT_X]; y = i[c_BIT_Y]; w = i[c_BIT_W]; z = i[c_BIT_Z];
            tt[i][c_BIT_A] = 1'($urandom);
            tt[i][c_BIT_B] = 1'b1;
            tt[i][c_BIT_C] = (x & z) | (w & z) | (y & z);
            tt[i][c_BIT_D] = (x & z) | (y & z) | (w & ~z);
            tt[i][c_BIT_E] = 1'($urandom);
        end
    endtask

    task automatic run_scan(input int s, input bit restart, input bit exact, input int exp_lat);
        int n;
        model_push(s);
        scan_open = 1;
        @(posedge clk); #1;
        sel = SW'(s);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        sel = SW'($urandom);
        n = 0;
        forever begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                check("first_stim", int'(stim), 0);
                check("busy_in_scan", int'(busy), 1);
            end
            if (n == 16) check("last_stim", int'(stim), 15);
            if (restart && n == 5) start = 1'b1;
            if (restart && n == 6) start = 1'b0;
            if (done) break;
            if (n >= 300) begin
                total++;
                bad++;
                $display("FAIL scan_timeout: got no done after %0d cycles expected done", n);
                break;
            end
        end
        if (exact) check("done_latency", n, exp_lat);
        else       check("done_latency_min", int'(n >= 18), 1);
        @(negedge clk);
        check("idle_after_done", int'(busy), 0);
    endtask

    // Consumer ready: always, random, or a 3-cycle stall on index 6
    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0: m_ready = 1'b1;
                1: m_ready = ($urandom_range(3) != 0);
                default: begin
                    if (m_valid && m_index == 4'd6 && stall_left > 0) begin
                        m_ready = 1'b0;
                        stall_left--;
                    end else begin
                        m_ready = 1'b1;
                    end
                end
            endcase
        end
    end

    // Monitor: handshake rules, beat scoreboard and end-of-scan results
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_stall = 1'b0;
                prev_done  = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("stall_valid_held", int'(m_valid), 1);
                    if (m_valid) begin
                        check("stall_index_stable", int'(m_index), int'(prev_idx));
                        check("stall_last_stable", int'(m_last), int'(prev_last));
                    end
                end
                if (m_valid && m_ready) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_beat: got index %0d expected none", m_index);
                    end else begin
                        mon_b = exp_q.pop_front();
                        check("beat_index", int'(m_index), int'(mon_b.idx));
                        check("beat_last", int'(m_last), int'(mon_b.last));
                    end
                end
                if (m_valid && !m_ready && m_index == 4'd6) stall6++;
                prev_stall = m_valid && !m_ready;
                prev_idx   = m_index;
                prev_last  = m_last;
                if (done) begin
                    done_seen++;
                    if (!scan_open) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_done: got done expected none");
                    end else begin
                        check("count", int'(count), exp_count);
                        check("beats_left", exp_q.size(), 0);
`ifdef SCAN_CONST_FLAG_EN
                        check("const_zero", int'(const_zero), int'(exp_count == 0));
                        check("const_one", int'(const_one), int'(exp_count == DEPTH));
`endif
                        scan_open = 0;
                    end
                    if (prev_done) begin
                        total++;
                        bad++;
                        $display("FAIL done_width: got done high 2 cycles expected 1");
                    end
                end
                prev_done = done;
            end
        end
    end

    initial begin
        int  n;
        int  d0;
        bit  hit;
        reset = 1'b1;
        start = 1'b0;
        sel   = '0;
        fill_const('0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_stim", int'(stim), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_valid", int'(m_valid), 0);
        check("rst_index", int'(m_index), 0);
        check("rst_last", int'(m_last), 0);
        check("rst_done", int'(done), 0);
        check("rst_count", int'(count), 0);
`ifdef SCAN_CONST_FLAG_EN
        check("rst_const_zero", int'(const_zero), 0);
        check("rst_const_one", int'(const_one), 0);
`endif
        @(posedge clk); #1;
        reset = 1'b0;

        // Guide functions
        fill_guide();
        rdy_mode = 0;
        run_scan(1, 0, 0, 0);
        run_scan(2, 0, 0, 0);
        rdy_mode = 2;
        stall_left = 3;
        stall6 = 0;
        run_scan(3, 0, 0, 0);
        check("stall_cycles_on_6", stall6, 3);
        rdy_mode = 0;

        // Constant-zero output, out-of-range select, restart during sweep
        fill_const('0);
        run_scan($urandom_range(7), 0, 1, 18);
        fill_const('1);
        run_scan(5, 0, 1, 18);
        fill_const('0);
        run_scan(2, 1, 1, 18);

        // Abort on the second beat of a full scan
        fill_const('1);
        model_push(1);
        scan_open = 1;
        @(posedge clk); #1;
        sel = SW'(1);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        hit = 0;
        for (int i = 0; i < 100 && !hit; i++) begin
            @(negedge clk);
            if (m_valid && m_index == 4'd1) hit = 1;
        end
        check("abort_reached_beat2", int'(hit), 1);
        #1;
        reset = 1'b1;
        exp_q.delete();
        scan_open = 0;
        d0 = done_seen;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("abort_valid", int'(m_valid), 0);
        check("abort_busy", int'(busy), 0);
        n = 0;
        repeat (30) begin
            @(negedge clk);
            if (done) n++;
        end
        check("abort_no_done", n + done_seen - d0, 0);
        run_scan(1, 0, 0, 0);

        // Random truth tables, random selects, random back-pressure
        rdy_mode = 1;
        for (int t = 0; t < 10; t++) begin
            for (int i = 0; i < DEPTH; i++) tt[i] = NF'($urandom);
            run_scan($urandom_range(7), 0, 0, 0);
        end
        rdy_mode = 0;

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
